// File: rtl/int_res_arbiter_pkg.sv
// Shared types and helpers for the intermediate-results memory arbiter.
// The bank-set helper is used by both the arbiter datapath and its checks.
package int_res_arbiter_pkg;

    localparam int unsigned CIM_INT_RES_BANK_SIZE_NUM_WORD = 256;
    localparam int unsigned INT_RES_NUM_BANKS              = 4;

    typedef logic [15:0] IntResAddr_t;

    typedef enum logic {
        SINGLE_WIDTH = 1'b0,
        DOUBLE_WIDTH = 1'b1
    } DataWidth_e;

    typedef enum logic [2:0] {
        INT_RES_SW_FX_1_X = 3'd0,
        INT_RES_SW_FX_2_X = 3'd1,
        INT_RES_SW_FX_3_X = 3'd2,
        INT_RES_SW_FX_4_X = 3'd3,
        INT_RES_SW_FX_5_X = 3'd4,
        INT_RES_DW_FX     = 3'd5
    } FxFormatIntRes_t;

    // Out-of-range addresses fold onto bank 0; double-width words span a bank pair.
    function automatic logic [3:0] int_res_bank_mask(
        input logic [31:0] addr,
        input DataWidth_e  width,
        input int unsigned depth = CIM_INT_RES_BANK_SIZE_NUM_WORD
    );
        logic [1:0] bank;
        logic [3:0] mask;
        if (addr >= 32'(INT_RES_NUM_BANKS * depth)) begin
            bank = '0;
        end else begin
            bank = 2'(addr / depth);
        end
        mask = 4'b0001 << bank;
        if (width == DOUBLE_WIDTH) begin
            mask = bank[0] ? 4'b1010 : 4'b0101;
        end
        return mask;
    endfunction

endpackage

// File: rtl/int_res_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search from ptr, first requester wins,
// next pointer lands just past the winner.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] next_ptr
);

    always_comb begin
        logic        found;
        int unsigned idx;
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[PTR_W'(idx)]) begin
                found                = 1'b1;
                grant[PTR_W'(idx)]   = 1'b1;
                next_ptr             = PTR_W'((idx + 1) % N);
            end
        end
    end

endmodule

// File: rtl/int_res_arbiter.sv
// Read/write round-robin arbiter for the banked intermediate-results memory,
// with bank-conflict deferral, starvation override and read-response routing.
module int_res_arbiter
    import int_res_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 22,
    parameter int unsigned FMT_W      = 3,
    parameter int unsigned BANK_DEPTH = CIM_INT_RES_BANK_SIZE_NUM_WORD,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_rd_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_rd_addr,
    input  logic [N_REQ-1:0]          req_rd_width,
    input  logic [N_REQ*FMT_W-1:0]    req_rd_format,
    output logic [N_REQ-1:0]          req_rd_ready,
    output logic [N_REQ-1:0]          rsp_rd_valid,
    output logic [DATA_W-1:0]         rsp_rd_data,
    input  logic [N_REQ-1:0]          req_wr_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_wr_addr,
    input  logic [N_REQ-1:0]          req_wr_width,
    input  logic [N_REQ*FMT_W-1:0]    req_wr_format,
    input  logic [N_REQ*DATA_W-1:0]   req_wr_data,
    output logic [N_REQ-1:0]          req_wr_ready,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    output logic                      mem_rd_width,
    output logic [FMT_W-1:0]          mem_rd_format,
    input  logic [DATA_W-1:0]         mem_rd_data,
    output logic                      mem_wr_en,
    output logic [ADDR_W-1:0]         mem_wr_addr,
    output logic                      mem_wr_width,
    output logic [FMT_W-1:0]          mem_wr_format,
    output logic [DATA_W-1:0]         mem_wr_data,
    output logic [1:0]                err_sticky
);

    localparam int unsigned PTR_W      = $clog2(N_REQ);
    localparam int unsigned STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [31:0] ADDR_LIMIT = 32'(INT_RES_NUM_BANKS * BANK_DEPTH);

    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, rd_ptr_nx;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, wr_ptr_nx;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                rsp_pend_q, rsp_pend_d;
    logic [PTR_W-1:0]    rsp_idx_q, rsp_idx_d;
    logic [FMT_W-1:0]    rsp_fmt_q, rsp_fmt_d;
    logic [1:0]          err_q, err_d;

    logic [N_REQ-1:0]    rd_cand, wr_cand;
    logic [PTR_W-1:0]    rd_idx, wr_idx;
    logic [ADDR_W-1:0]   rd_addr, wr_addr;
    logic                rd_width, wr_width;
    logic [FMT_W-1:0]    rd_fmt, wr_fmt;
    logic [DATA_W-1:0]   wr_data;
    logic [3:0]          rd_mask, wr_mask;
    logic                rd_any, wr_any, conflict, rd_gnt, wr_gnt;
    logic                rd_oor, wr_oor, rd_dw_bad, wr_dw_bad, rsp_on;

    rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rd_rr (
        .req      (req_rd_valid),
        .ptr      (rd_ptr_q),
        .grant    (rd_cand),
        .next_ptr (rd_ptr_nx)
    );

    rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_wr_rr (
        .req      (req_wr_valid),
        .ptr      (wr_ptr_q),
        .grant    (wr_cand),
        .next_ptr (wr_ptr_nx)
    );

    always_comb begin
        rd_idx = '0;
        wr_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rd_cand[i]) rd_idx = PTR_W'(i);
            if (wr_cand[i]) wr_idx = PTR_W'(i);
        end
        rd_addr  = req_rd_addr[rd_idx*ADDR_W +: ADDR_W];
        rd_width = req_rd_width[rd_idx];
        rd_fmt   = req_rd_format[rd_idx*FMT_W +: FMT_W];
        wr_addr  = req_wr_addr[wr_idx*ADDR_W +: ADDR_W];
        wr_width = req_wr_width[wr_idx];
        wr_fmt   = req_wr_format[wr_idx*FMT_W +: FMT_W];
        wr_data  = req_wr_data[wr_idx*DATA_W +: DATA_W];
    end

    // Candidates lose their grant for a cycle when the read and write bank sets overlap.
    always_comb begin
        rd_any   = (|rd_cand) && !rst;
        wr_any   = (|wr_cand) && !rst;
        rd_mask  = int_res_bank_mask(32'(rd_addr), DataWidth_e'(rd_width), BANK_DEPTH);
        wr_mask  = int_res_bank_mask(32'(wr_addr), DataWidth_e'(wr_width), BANK_DEPTH);
        conflict = rd_any && wr_any && (|(rd_mask & wr_mask));
        rd_gnt   = rd_any && !(conflict && (starve_q >= STARVE_W'(STARVE_MAX)));
        wr_gnt   = wr_any && !(conflict && (starve_q <  STARVE_W'(STARVE_MAX)));
        rsp_on   = rsp_pend_q && !rst;

        rd_oor    = 32'(rd_addr) >= ADDR_LIMIT;
        wr_oor    = 32'(wr_addr) >= ADDR_LIMIT;
        rd_dw_bad = rd_width && (rd_fmt != FMT_W'(INT_RES_DW_FX));
        wr_dw_bad = wr_width && (wr_fmt != FMT_W'(INT_RES_DW_FX));
    end

    always_comb begin
        req_rd_ready  = rd_gnt ? rd_cand : '0;
        req_wr_ready  = wr_gnt ? wr_cand : '0;

        mem_rd_en     = rd_gnt;
        mem_rd_addr   = rd_gnt ? rd_addr  : '0;
        mem_rd_width  = rd_gnt ? rd_width : 1'b0;
        // Format is needed on the memory's data cycle, so it lingers one cycle after a grant.
        mem_rd_format = rd_gnt ? rd_fmt : (rsp_on ? rsp_fmt_q : '0);

        mem_wr_en     = wr_gnt;
        mem_wr_addr   = wr_gnt ? wr_addr  : '0;
        mem_wr_width  = wr_gnt ? wr_width : 1'b0;
        mem_wr_format = wr_gnt ? wr_fmt   : '0;
        mem_wr_data   = wr_gnt ? wr_data  : '0;

        rsp_rd_valid  = rsp_on ? (N_REQ'(1) << rsp_idx_q) : '0;
        rsp_rd_data   = rsp_on ? mem_rd_data : '0;
        err_sticky    = err_q;
    end

    always_comb begin
        rd_ptr_d   = rd_gnt ? rd_ptr_nx : rd_ptr_q;
        wr_ptr_d   = wr_gnt ? wr_ptr_nx : wr_ptr_q;
        starve_d   = starve_q;
        if (wr_gnt) begin
            starve_d = '0;
        end else if (conflict && (starve_q < STARVE_W'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
        rsp_pend_d = rd_gnt;
        rsp_idx_d  = rd_gnt ? rd_idx : rsp_idx_q;
        rsp_fmt_d  = rd_gnt ? rd_fmt : rsp_fmt_q;
        err_d      = err_q;
        err_d[0]   = err_q[0] | (rd_gnt & rd_oor)    | (wr_gnt & wr_oor);
        err_d[1]   = err_q[1] | (rd_gnt & rd_dw_bad) | (wr_gnt & wr_dw_bad);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            starve_q   <= '0;
            rsp_pend_q <= 1'b0;
            rsp_idx_q  <= '0;
            rsp_fmt_q  <= '0;
            err_q      <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            starve_q   <= starve_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_idx_q  <= rsp_idx_d;
            rsp_fmt_q  <= rsp_fmt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_int_res_arbiter.sv
// Directed and randomized bench for int_res_arbiter against a cycle-level
// reference model built from the arbitration rules.
module tb_int_res_arbiter;
    import int_res_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 22;
    localparam int FW = 3;
    localparam int BD = CIM_INT_RES_BANK_SIZE_NUM_WORD;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_rd_valid, req_rd_width, req_rd_ready, rsp_rd_valid;
    logic [N*AW-1:0] req_rd_addr, req_wr_addr;
    logic [N*FW-1:0] req_rd_format, req_wr_format;
    logic [DW-1:0]   rsp_rd_data, mem_data_drv, mem_wr_data;
    logic [N-1:0]    req_wr_valid, req_wr_width, req_wr_ready;
    logic [N*DW-1:0] req_wr_data;
    logic            mem_rd_en, mem_rd_width, mem_wr_en, mem_wr_width;
    logic [AW-1:0]   mem_rd_addr, mem_wr_addr;
    logic [FW-1:0]   mem_rd_format, mem_wr_format;
    logic [1:0]      err_sticky;

    int_res_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .FMT_W(FW), .BANK_DEPTH(BD), .STARVE_MAX(SM)
    ) dut (
        .clk(clk), .rst(rst),
        .req_rd_valid(req_rd_valid), .req_rd_addr(req_rd_addr), .req_rd_width(req_rd_width),
        .req_rd_format(req_rd_format), .req_rd_ready(req_rd_ready),
        .rsp_rd_valid(rsp_rd_valid), .rsp_rd_data(rsp_rd_data),
        .req_wr_valid(req_wr_valid), .req_wr_addr(req_wr_addr), .req_wr_width(req_wr_width),
        .req_wr_format(req_wr_format), .req_wr_data(req_wr_data), .req_wr_ready(req_wr_ready),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_width(mem_rd_width),
        .mem_rd_format(mem_rd_format), .mem_rd_data(mem_data_drv),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_width(mem_wr_width),
        .mem_wr_format(mem_wr_format), .mem_wr_data(mem_wr_data),
        .err_sticky(err_sticky)
    );

    int checks = 0;
    int failures = 0;

    // Requester-side stimulus state
    bit [N-1:0]  rv, rw, wv, ww;
    int unsigned ra[N], rf[N], wa[N], wf[N], wd[N];

    // Reference model state
    int          m_rd_ptr, m_wr_ptr, m_starve, m_pidx;
    bit          m_pend;
    int unsigned m_pfmt;
    bit [1:0]    m_err;
    int          g_rd, g_wr;

    // Observations captured at the last check point
    logic [N-1:0]  o_rd_ready, o_wr_ready, o_rsp_valid;
    logic [DW-1:0] o_rsp_data;
    logic [FW-1:0] o_rd_fmt;
    logic [1:0]    o_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input bit [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int unsigned bank_of(input int unsigned a);
        return (a >= 4 * BD) ? 0 : a / BD;
    endfunction

    // A double-width access covers every bank of one parity.
    function automatic bit overlap(input int unsigned a1, input bit w1,
                                   input int unsigned a2, input bit w2);
        if (w1 || w2) return (bank_of(a1) % 2) == (bank_of(a2) % 2);
        return bank_of(a1) == bank_of(a2);
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_rd_valid[i]             = rv[i];
            req_rd_width[i]             = rw[i];
            req_rd_addr[i*AW +: AW]     = AW'(ra[i]);
            req_rd_format[i*FW +: FW]   = FW'(rf[i]);
            req_wr_valid[i]             = wv[i];
            req_wr_width[i]             = ww[i];
            req_wr_addr[i*AW +: AW]     = AW'(wa[i]);
            req_wr_format[i*FW +: FW]   = FW'(wf[i]);
            req_wr_data[i*DW +: DW]     = DW'(wd[i]);
        end
    endtask

    task automatic step();
        int rc, wc;
        bit conf, rwin, wwin, rsp_on;
        pack();
        #2;
        rc = rst ? -1 : pick(rv, m_rd_ptr);
        wc = rst ? -1 : pick(wv, m_wr_ptr);
        conf   = (rc >= 0) && (wc >= 0) && overlap(ra[rc], rw[rc], wa[wc], ww[wc]);
        rwin   = (rc >= 0) && !(conf && m_starve >= SM);
        wwin   = (wc >= 0) && !(conf && m_starve < SM);
        rsp_on = m_pend && !rst;

        chk("rd_ready",  64'(req_rd_ready),  rwin ? (64'(1) << rc) : 64'(0));
        chk("wr_ready",  64'(req_wr_ready),  wwin ? (64'(1) << wc) : 64'(0));
        chk("rd_en",     64'(mem_rd_en),     64'(rwin));
        chk("rd_addr",   64'(mem_rd_addr),   rwin ? 64'(ra[rc]) : 64'(0));
        chk("rd_width",  64'(mem_rd_width),  rwin ? 64'(rw[rc]) : 64'(0));
        chk("rd_format", 64'(mem_rd_format), rwin ? 64'(rf[rc]) : (rsp_on ? 64'(m_pfmt) : 64'(0)));
        chk("rsp_valid", 64'(rsp_rd_valid),  rsp_on ? (64'(1) << m_pidx) : 64'(0));
        chk("rsp_data",  64'(rsp_rd_data),   rsp_on ? 64'(mem_data_drv) : 64'(0));
        chk("wr_en",     64'(mem_wr_en),     64'(wwin));
        chk("wr_addr",   64'(mem_wr_addr),   wwin ? 64'(wa[wc]) : 64'(0));
        chk("wr_width",  64'(mem_wr_width),  wwin ? 64'(ww[wc]) : 64'(0));
        chk("wr_format", 64'(mem_wr_format), wwin ? 64'(wf[wc]) : 64'(0));
        chk("wr_data",   64'(mem_wr_data),   wwin ? 64'(DW'(wd[wc])) : 64'(0));
        chk("err",       64'(err_sticky),    64'(m_err));

        o_rd_ready = req_rd_ready;  o_wr_ready = req_wr_ready;
        o_rsp_valid = rsp_rd_valid; o_rsp_data = rsp_rd_data;
        o_rd_fmt = mem_rd_format;   o_err = err_sticky;
        g_rd = rwin ? rc : -1;
        g_wr = wwin ? wc : -1;

        @(posedge clk);
        #1;
        if (rst) begin
            m_rd_ptr = 0; m_wr_ptr = 0; m_starve = 0; m_pend = 0;
            m_pidx = 0; m_pfmt = 0; m_err = 0;
        end else begin
            if (rwin) m_rd_ptr = (rc + 1) % N;
            if (wwin) m_wr_ptr = (wc + 1) % N;
            if (wwin) m_starve = 0;
            else if (conf) m_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
            m_pend = rwin;
            if (rwin) begin
                m_pidx = rc;
                m_pfmt = rf[rc];
                if (ra[rc] >= 4 * BD) m_err[0] = 1'b1;
                if (rw[rc] && rf[rc] != int'(INT_RES_DW_FX)) m_err[1] = 1'b1;
            end
            if (wwin) begin
                if (wa[wc] >= 4 * BD) m_err[0] = 1'b1;
                if (ww[wc] && wf[wc] != int'(INT_RES_DW_FX)) m_err[1] = 1'b1;
            end
        end
    endtask

    task automatic clear_reqs();
        rv = '0; rw = '0; wv = '0; ww = '0;
        for (int i = 0; i < N; i++) begin
            ra[i] = 0; rf[i] = 0; wa[i] = 0; wf[i] = 0; wd[i] = 0;
        end
    endtask

    initial begin
        clear_reqs();
        mem_data_drv = '0;
        m_rd_ptr = 0; m_wr_ptr = 0; m_starve = 0; m_pend = 0;
        m_pidx = 0; m_pfmt = 0; m_err = 0; g_rd = -1; g_wr = -1;
        pack();
        @(posedge clk);
        #1;
        step();                                    // reset state

        // Alternating round-robin reads with routed responses
        rst = 1'b0;
        rv = 4'b0101; ra[0] = 10; ra[2] = BD + 1; rf[0] = 1; rf[2] = 2;
        step();
        chk("t1_gnt_a", 64'(o_rd_ready), 64'(4'b0001));
        mem_data_drv = 22'h1234;
        step();
        chk("t1_gnt_b", 64'(o_rd_ready), 64'(4'b0100));
        chk("t1_rsp_a", 64'(o_rsp_valid), 64'(4'b0001));
        chk("t1_dat_a", 64'(o_rsp_data), 64'(22'h1234));
        mem_data_drv = 22'h0567;
        step();
        chk("t1_gnt_c", 64'(o_rd_ready), 64'(4'b0001));
        chk("t1_rsp_b", 64'(o_rsp_valid), 64'(4'b0100));
        chk("t1_dat_b", 64'(o_rsp_data), 64'(22'h0567));
        step();
        clear_reqs();
        step();

        // Non-conflicting read and write in the same cycle
        rv[1] = 1'b1; ra[1] = 5;
        wv[3] = 1'b1; wa[3] = BD + 5; wd[3] = 22'h2AAAA;
        step();
        chk("t2_rd", 64'(o_rd_ready), 64'(4'b0010));
        chk("t2_wr", 64'(o_wr_ready), 64'(4'b1000));
        clear_reqs();
        step();

        // Conflict: write deferred STARVE_MAX cycles, then wins
        rv[0] = 1'b1; ra[0] = 3;
        wv[1] = 1'b1; wa[1] = 2 * BD + 7; ww[1] = 1'b1; wf[1] = INT_RES_DW_FX;
        for (int k = 0; k < SM; k++) begin
            step();
            chk("t3_rd_win", 64'(o_rd_ready), 64'(4'b0001));
            chk("t3_wr_held", 64'(o_wr_ready), 64'(0));
        end
        step();
        chk("t3_rd_held", 64'(o_rd_ready), 64'(0));
        chk("t3_wr_win", 64'(o_wr_ready), 64'(4'b0010));
        clear_reqs();
        step();

        // Read format held through the data cycle
        rv[2] = 1'b1; ra[2] = 3 * BD + 1; rf[2] = INT_RES_SW_FX_2_X;
        step();
        chk("t4_fmt_t0", 64'(o_rd_fmt), 64'(INT_RES_SW_FX_2_X));
        clear_reqs();
        step();
        chk("t4_fmt_t1", 64'(o_rd_fmt), 64'(INT_RES_SW_FX_2_X));
        chk("t4_rsp", 64'(o_rsp_valid), 64'(4'b0100));
        step();
        chk("t4_fmt_t2", 64'(o_rd_fmt), 64'(0));

        // Reset right after a grant suppresses the response and clears pointers
        rv[1] = 1'b1; ra[1] = 7;
        step();
        clear_reqs();
        rst = 1'b1;
        step();
        chk("t5_rsp_sup", 64'(o_rsp_valid), 64'(0));
        rst = 1'b0;
        step();
        chk("t5_idle_rsp", 64'(o_rsp_valid), 64'(0));
        rv = 4'b0101;
        step();
        chk("t5_ptr0", 64'(o_rd_ready), 64'(4'b0001));
        clear_reqs();
        step();

        // Sticky error bits
        wv[0] = 1'b1; wa[0] = 4 * BD;
        step();
        clear_reqs();
        step();
        chk("t6_oor", 64'(o_err), 64'(2'b01));
        step();
        chk("t6_oor_hold", 64'(o_err), 64'(2'b01));
        rv[0] = 1'b1; ra[0] = 0; rw[0] = 1'b1; rf[0] = INT_RES_SW_FX_5_X;
        step();
        clear_reqs();
        step();
        chk("t6_dw", 64'(o_err), 64'(2'b11));
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("t6_clr", 64'(o_err), 64'(2'b00));

        // Randomized traffic; requesters hold until granted
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            mem_data_drv = DW'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!rv[i] || g_rd == i) begin
                    rv[i] = ($urandom_range(0, 2) != 0);
                    ra[i] = $urandom_range(0, 4 * BD + 8);
                    rw[i] = $urandom_range(0, 1);
                    rf[i] = $urandom_range(0, 5);
                end
                if (!wv[i] || g_wr == i) begin
                    wv[i] = ($urandom_range(0, 2) != 0);
                    wa[i] = $urandom_range(0, 4 * BD + 8);
                    ww[i] = $urandom_range(0, 1);
                    wf[i] = $urandom_range(0, 5);
                    wd[i] = $urandom;
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_res_arbiter.md
Name: int_res_arbiter

Overview:
- Shares the intermediate-results memory between N_REQ compute requesters.
- Round-robin arbitrates independently on the read and write ports.
- Defers one side when the granted read and write hit the same single-port bank, with a bounded-starvation override.
- Holds read format through the 1-cycle read latency and routes read data back to the requester that issued it.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 16, width of a flat intermediate-results address (IntResAddr_t).
- DATA_W, 22, width of the compute-format data word (N_COMP).
- FMT_W, 3, width of FxFormatIntRes_t.
- BANK_DEPTH, CIM_INT_RES_BANK_SIZE_NUM_WORD, words per bank; 4 banks total.
- STARVE_MAX, 4, consecutive conflict losses after which the write side wins.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_rd_valid  in  N_REQ  read request per requester.
- req_rd_addr  in  N_REQ*ADDR_W  read address, requester i at slice i.
- req_rd_width  in  N_REQ  0=SINGLE_WIDTH, 1=DOUBLE_WIDTH.
- req_rd_format  in  N_REQ*FMT_W  read format.
- req_rd_ready  out  N_REQ  one-hot read grant.
- rsp_rd_valid  out  N_REQ  one-hot, read data valid for requester i.
- rsp_rd_data  out  DATA_W  read data, broadcast to all requesters.
- req_wr_valid / req_wr_addr / req_wr_width / req_wr_format  in  same widths as read side  write request.
- req_wr_data  in  N_REQ*DATA_W  write data.
- req_wr_ready  out  N_REQ  one-hot write grant.
- mem_rd_en / mem_rd_addr / mem_rd_width / mem_rd_format  out  1/ADDR_W/1/FMT_W  memory read interface.
- mem_rd_data  in  DATA_W  memory read data, valid 1 cycle after mem_rd_en.
- mem_wr_en / mem_wr_addr / mem_wr_width / mem_wr_format / mem_wr_data  out  1/ADDR_W/1/FMT_W/DATA_W  memory write interface.
- err_sticky  out  2  bit0: out-of-range address granted; bit1: DOUBLE_WIDTH granted with format != INT_RES_DW_FX.

Behaviour:
- Handshake:
  - A transfer occurs when valid[i] and ready[i] are both high.
  - ready is combinational from valid, round-robin pointer and conflict state.
  - At most one read grant and one write grant per cycle.
  - Requesters must hold valid, addr, width, format and data stable until ready.
- Round-robin:
  - Separate rd_ptr and wr_ptr.
  - Search starts at the pointer index; the first valid requester wins.
  - After a grant, the pointer moves to the granted index + 1 mod N_REQ.
  - The pointer is unchanged when nothing is granted.
- Memory outputs:
  - Combinational copy of the granted request.
  - en=1 only on a grant; addr, data and width are 0 when en=0.
- Bank sets: bank = addr / BANK_DEPTH.
  - SINGLE_WIDTH uses {bank}.
  - DOUBLE_WIDTH uses {0,2} if bank is 0 or 2, and {1,3} if bank is 1 or 3.
  - addr >= 4*BANK_DEPTH maps to bank 0.
- Conflict: the read and write candidates' bank sets intersect.
  - If starve_cnt < STARVE_MAX: read granted, write held, starve_cnt += 1.
  - Else: write granted, read held, starve_cnt = 0.
  - Any write grant clears starve_cnt.
  - starve_cnt saturates at STARVE_MAX.
- Read latency:
  - On read grant at cycle T, register the requester index and format.
  - mem_rd_format keeps driving the registered format during T+1, because the memory applies format on its data cycle. Exception: a new grant at T+1 drives the new format, which is legal since the memory registers nothing format-related.
  - rsp_rd_valid[idx]=1 and rsp_rd_data=mem_rd_data at T+1.
  - Back-to-back reads give one response per cycle.
- Errors: err_sticky bits are set on a granted offending request and cleared only by rst.
- Reset values:
  - All outputs 0.
  - rd_ptr=wr_ptr=0, starve_cnt=0, pending-response flag 0.
  - A rst asserted at T+1 after a grant suppresses that response (rsp_rd_valid=0).
- Simultaneous read and write to the same address without conflict is impossible, because same address means same bank; the conflict rule applies.

Decomposition:
- Defines package: DataWidth_e, FxFormatIntRes_t, IntResAddr_t, CIM_INT_RES_BANK_SIZE_NUM_WORD, INT_RES_DW_FX, plus a new function int_res_bank_mask(addr, width) returning a 4-bit bank set, shared with assertions.
- One sub-module rr_arbiter (N param; req, ptr -> one-hot grant, next ptr), instantiated twice.

Test Plan:
- Reqs 0,2 read-valid every cycle, no writes: grants alternate 0,2,0,2. rsp_rd_valid follows one cycle later with mem data 0x1234 then 0x0567.
- Read from req 1 at addr 5, SINGLE, and write from req 3 at addr BANK_DEPTH+5, no conflict: both granted in the same cycle.
- Read from req 0 at addr 3 (bank 0) held valid with a write at 2*BANK_DEPTH+7, DOUBLE (banks 0,2): write deferred 4 cycles, granted on the 5th, read held that cycle.
- Read format INT_RES_SW_FX_2_X granted at T: mem_rd_format equals it at T and T+1 when idle at T+1.
- Grant at T, rst at T+1: rsp_rd_valid=0 at T+1; pointers 0 and all outputs 0 at T+2.
- Write at addr 4*BANK_DEPTH granted: err_sticky=2'b01 stays set until rst. DOUBLE read with INT_RES_SW_FX_5_X: bit1 set.
